// File: rtl/tetris_pkg.sv
// Shared board constants, cell/color types, fetcher FSM states and the cell palette.
// The board logic and the row fetcher both use this palette.
package tetris_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam int CELL_W  = 3;

  typedef logic [CELL_W-1:0] cell_t;
  typedef logic [15:0]       color_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_COMMIT
  } fetch_state_t;

  function automatic color_t palette(cell_t code);
    case (code)
      3'd0:    palette = 16'h0000;
      3'd1:    palette = 16'h00FF;
      3'd2:    palette = 16'h00F0;
      3'd3:    palette = 16'h0F00;
      3'd4:    palette = 16'h0FF0;
      3'd5:    palette = 16'h0F0F;
      3'd6:    palette = 16'h0F80;
      3'd7:    palette = 16'h000F;
      default: palette = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/board_row_fetcher_if.sv
// Bus between the VGA color mapper / board RAM / piece logic (master) and the row fetcher (slave).
// LD_Row is a level; a fetch starts only on its rising edge while the fetcher is idle. busy is high
// while a fetch is in flight, and rowReady pulses for one cycle in the first cycle Row shows new data.
// ram_rdata must be valid exactly one cycle after ram_addr.
interface board_row_fetcher_if;
  import tetris_pkg::*;

  logic        LD_Row;
  logic [7:0]  rowNum;
  logic [7:0]  ram_addr;
  cell_t       ram_rdata;
  logic        piece_valid;
  logic [3:0]  piece_x [4];
  logic [4:0]  piece_y [4];
  cell_t       piece_type;
  color_t      Row [BOARD_W];
  logic        rowReady;
  logic        busy;

  modport master (
    output LD_Row, rowNum, ram_rdata, piece_valid, piece_x, piece_y, piece_type,
    input  ram_addr, Row, rowReady, busy
  );

  modport slave (
    input  LD_Row, rowNum, ram_rdata, piece_valid, piece_x, piece_y, piece_type,
    output ram_addr, Row, rowReady, busy
  );

endinterface

// File: rtl/board_row_fetcher_cell_overlay.sv
// Color of one captured cell: the falling piece wins over the RAM cell code, and rows
// below the board are always blank.
module cell_overlay
  import tetris_pkg::*;
(
  input  logic [3:0] col,
  input  logic [7:0] row_q,
  input  logic       piece_valid,
  input  logic [3:0] piece_x [4],
  input  logic [4:0] piece_y [4],
  input  cell_t      piece_type,
  input  cell_t      ram_rdata,
  output color_t     color
);

  logic hit;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (piece_x[i] == col && {3'b000, piece_y[i]} == row_q) hit = 1'b1;
    end

    if (row_q >= 8'(BOARD_H))      color = '0;
    else if (piece_valid && hit)   color = palette(piece_type);
    else                           color = palette(ram_rdata);
  end

endmodule

// File: rtl/board_row_fetcher.sv
// Reads one board row from RAM, overlays the falling piece into a shadow buffer,
// then commits the whole Row array in a single cycle so the mapper never sees a partial row.
module board_row_fetcher
  import tetris_pkg::*;
(
  input  logic                 Clk,
  input  logic                 reset,
  board_row_fetcher_if.slave   bus,
  output fetch_state_t         state_dbg
);

  fetch_state_t state, state_nxt;
  logic         ld_q;
  logic         start;
  logic [7:0]   row_q;
  logic [3:0]   col, col_nxt;
  logic [3:0]   cap_col;
  logic         capture;
  logic [7:0]   ram_addr_c;
  color_t       cell_color;
  color_t       shadow [BOARD_W];
  color_t       row_r  [BOARD_W];
  logic         row_ready_r;

  assign start = bus.LD_Row & ~ld_q;

  always_ff @(posedge Clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ld_q  <= 1'b0;
      row_q <= '0;
      col   <= '0;
    end else begin
      state <= state_nxt;
      ld_q  <= bus.LD_Row;
      col   <= col_nxt;
      if (state == ST_IDLE && start) row_q <= bus.rowNum;
    end
  end

  // RAM data lags the address by one cycle, so each FETCH cycle captures the previous
  // column and DRAIN picks up the last one.
  always_comb begin
    state_nxt  = state;
    col_nxt    = col;
    capture    = 1'b0;
    cap_col    = col - 4'd1;
    ram_addr_c = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_FETCH;
          col_nxt   = '0;
        end
      end
      ST_FETCH: begin
        if (row_q < 8'(BOARD_H)) ram_addr_c = row_q * 8'(BOARD_W) + {4'b0000, col};
        capture = (col != 4'd0);
        if (col == 4'(BOARD_W - 1)) state_nxt = ST_DRAIN;
        else                        col_nxt   = col + 4'd1;
      end
      ST_DRAIN: begin
        capture   = 1'b1;
        cap_col   = 4'(BOARD_W - 1);
        state_nxt = ST_COMMIT;
      end
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  cell_overlay u_cell_overlay (
    .col         (cap_col),
    .row_q       (row_q),
    .piece_valid (bus.piece_valid),
    .piece_x     (bus.piece_x),
    .piece_y     (bus.piece_y),
    .piece_type  (bus.piece_type),
    .ram_rdata   (bus.ram_rdata),
    .color       (cell_color)
  );

  always_ff @(posedge Clk) begin
    if (reset) begin
      for (int k = 0; k < BOARD_W; k++) begin
        shadow[k] <= '0;
        row_r[k]  <= '0;
      end
      row_ready_r <= 1'b0;
    end else begin
      if (capture) shadow[cap_col] <= cell_color;
      if (state == ST_COMMIT) row_r <= shadow;
      row_ready_r <= (state == ST_COMMIT);
    end
  end

  assign bus.ram_addr = ram_addr_c;
  assign bus.Row      = row_r;
  assign bus.rowReady = row_ready_r;
  assign bus.busy     = (state != ST_IDLE);
  assign state_dbg    = state;

endmodule

// File: tb/tb_board_row_fetcher.sv
// Self-checking bench for board_row_fetcher: randomized RAM contents, rows and piece
// placements checked against a cell-by-cell reference model of the row colors.
module tb_board_row_fetcher;
  import tetris_pkg::*;

  logic Clk = 1'b0;
  logic reset;
  always #5 Clk = ~Clk;

  board_row_fetcher_if bus ();
  fetch_state_t state_dbg;

  board_row_fetcher dut (
    .Clk       (Clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // Board RAM model: synchronous read, data one cycle after the address.
  logic [2:0] mem [256];
  always @(posedge Clk) bus.ram_rdata <= mem[bus.ram_addr];

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];
  logic [15:0] pal_tab [8];
  logic [15:0] last_row [10];

  logic [7:0]  obs_addr  [14];
  logic        obs_ready [14];
  logic        obs_busy  [14];
  logic [15:0] obs_row   [10];
  logic [15:0] obs_pre   [10];

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_color(int r, int c);
    if (r >= 20) return 16'h0000;
    if (bus.piece_valid)
      for (int i = 0; i < 4; i++)
        if (int'(bus.piece_x[i]) == c && int'(bus.piece_y[i]) == r) return pal_tab[bus.piece_type];
    return pal_tab[mem[r * 10 + c]];
  endfunction

  task automatic push_expected(input int r);
    for (int c = 0; c < 10; c++) exp_q.push_back(ref_color(r, c));
  endtask

  // ---------------- drivers ----------------
  task automatic clear_piece();
    bus.piece_valid = 1'b0;
    bus.piece_type  = '0;
    for (int i = 0; i < 4; i++) begin
      bus.piece_x[i] = '0;
      bus.piece_y[i] = 5'd31;
    end
  endtask

  // Requests a row and records ram_addr/rowReady/busy for the 14 cycles after the start edge.
  task automatic drive_fetch(input logic [7:0] row);
    @(negedge Clk);
    bus.LD_Row = 1'b1;
    bus.rowNum = row;
    @(posedge Clk);
    for (int j = 0; j < 14; j++) begin
      @(negedge Clk);
      obs_addr[j]  = bus.ram_addr;
      obs_ready[j] = bus.rowReady;
      obs_busy[j]  = bus.busy;
      if (j == 11) for (int k = 0; k < 10; k++) obs_pre[k] = bus.Row[k];
      if (j == 12) for (int k = 0; k < 10; k++) obs_row[k] = bus.Row[k];
      if (j == 2) begin
        bus.LD_Row = 1'b0;
        bus.rowNum = 8'($urandom);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge Clk);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (bus.Row[k] !== 16'h0000) begin
        errors++; $display("FAIL reset_row[%0d]: got %h expected 0000", k, bus.Row[k]);
      end
      last_row[k] = 16'h0000;
    end
    checks++;
    if (bus.rowReady !== 1'b0 || bus.busy !== 1'b0 || bus.ram_addr !== 8'd0 || state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_outputs: rowReady=%b busy=%b ram_addr=%0d state=%0d expected 0 0 0 0",
               bus.rowReady, bus.busy, bus.ram_addr, state_dbg);
    end
    reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_normal();
    for (int a = 0; a < 256; a++) mem[a] = 3'(a % 8);
    clear_piece();
    push_expected(3);
    drive_fetch(8'd3);
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (obs_addr[j] !== 8'(30 + j)) begin
        errors++; $display("FAIL normal_addr[%0d]: got %0d expected %0d", j, obs_addr[j], 30 + j);
      end
    end
    for (int j = 0; j < 14; j++) begin
      checks++;
      if (obs_ready[j] !== (j == 12) || obs_busy[j] !== (j < 12)) begin
        errors++;
        $display("FAIL normal_timing[%0d]: rowReady=%b busy=%b expected %b %b",
                 j, obs_ready[j], obs_busy[j], (j == 12), (j < 12));
      end
    end
    checks++;
    if (obs_row[0] !== 16'h0F80) begin
      errors++; $display("FAIL normal_row0: got %h expected 0F80", obs_row[0]);
    end
    for (int k = 0; k < 10; k++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      checks++;
      if (obs_row[k] !== e) begin
        errors++; $display("FAIL normal_row[%0d]: got %h expected %h", k, obs_row[k], e);
      end
      checks++;
      if (obs_pre[k] !== last_row[k]) begin
        errors++; $display("FAIL normal_stable[%0d]: got %h expected %h", k, obs_pre[k], last_row[k]);
      end
      last_row[k] = e;
    end
  endtask

  task automatic test_overlay();
    logic [15:0] e;
    for (int a = 0; a < 256; a++) mem[a] = 3'd0;
    bus.piece_valid = 1'b1;
    bus.piece_type  = 3'd2;
    bus.piece_x[0] = 4'd4; bus.piece_y[0] = 5'd3;
    bus.piece_x[1] = 4'd5; bus.piece_y[1] = 5'd3;
    bus.piece_x[2] = 4'd4; bus.piece_y[2] = 5'd4;
    bus.piece_x[3] = 4'd5; bus.piece_y[3] = 5'd4;
    drive_fetch(8'd3);
    for (int k = 0; k < 10; k++) begin
      e = (k == 4 || k == 5) ? 16'h00F0 : 16'h0000;
      checks++;
      if (obs_row[k] !== e) begin
        errors++; $display("FAIL overlay_row[%0d]: got %h expected %h", k, obs_row[k], e);
      end
      last_row[k] = e;
    end
    clear_piece();
  endtask

  task automatic test_blank();
    for (int a = 0; a < 256; a++) mem[a] = 3'($urandom_range(1, 7));
    bus.piece_valid = 1'b1;
    bus.piece_type  = 3'd5;
    for (int i = 0; i < 4; i++) begin
      bus.piece_x[i] = 4'(i + 2);
      bus.piece_y[i] = 5'd21;
    end
    drive_fetch(8'd21);
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (obs_addr[j] !== 8'd0) begin
        errors++; $display("FAIL blank_addr[%0d]: got %0d expected 0", j, obs_addr[j]);
      end
    end
    checks++;
    if (obs_ready[12] !== 1'b1 || obs_ready[11] !== 1'b0) begin
      errors++; $display("FAIL blank_ready: got %b%b expected 01", obs_ready[11], obs_ready[12]);
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (obs_row[k] !== 16'h0000) begin
        errors++; $display("FAIL blank_row[%0d]: got %h expected 0000", k, obs_row[k]);
      end
      last_row[k] = 16'h0000;
    end
    clear_piece();
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      int r;
      logic [15:0] e;
      r = $urandom_range(0, 23);
      for (int a = 0; a < 256; a++) mem[a] = 3'($urandom_range(0, 7));
      bus.piece_valid = 1'($urandom_range(0, 1));
      bus.piece_type  = 3'($urandom_range(0, 7));
      for (int i = 0; i < 4; i++) begin
        bus.piece_x[i] = 4'($urandom_range(0, 11));
        bus.piece_y[i] = ($urandom_range(0, 2) != 0) ? 5'(r) : 5'($urandom_range(0, 31));
      end
      push_expected(r);
      drive_fetch(8'(r));
      for (int j = 0; j < 10; j++) begin
        checks++;
        if (obs_addr[j] !== ((r < 20) ? 8'(r * 10 + j) : 8'd0)) begin
          errors++; $display("FAIL rand%0d_addr[%0d]: got %0d row %0d", n, j, obs_addr[j], r);
        end
      end
      for (int j = 0; j < 14; j++) begin
        checks++;
        if (obs_ready[j] !== (j == 12) || obs_busy[j] !== (j < 12)) begin
          errors++;
          $display("FAIL rand%0d_timing[%0d]: rowReady=%b busy=%b expected %b %b",
                   n, j, obs_ready[j], obs_busy[j], (j == 12), (j < 12));
        end
      end
      for (int k = 0; k < 10; k++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_row[k] !== e) begin
          errors++; $display("FAIL rand%0d_row[%0d]: got %h expected %h row %0d", n, k, obs_row[k], e, r);
        end
        checks++;
        if (obs_pre[k] !== last_row[k]) begin
          errors++; $display("FAIL rand%0d_stable[%0d]: got %h expected %h", n, k, obs_pre[k], last_row[k]);
        end
        last_row[k] = e;
      end
    end
    clear_piece();
  endtask

  task automatic test_level();
    int cnt;
    @(negedge Clk);
    bus.LD_Row = 1'b1;
    bus.rowNum = 8'd7;
    cnt = 0;
    repeat (400) begin
      @(negedge Clk);
      if (bus.rowReady) cnt++;
    end
    checks++;
    if (cnt !== 1) begin
      errors++; $display("FAIL level_hold: got %0d commits expected 1", cnt);
    end
    bus.LD_Row = 1'b0;
    repeat (2) @(negedge Clk);
    bus.LD_Row = 1'b1;
    @(posedge Clk);
    cnt = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge Clk);
      if (bus.rowReady) cnt++;
      if (j == 4) bus.LD_Row = 1'b0;
      if (j == 5) bus.LD_Row = 1'b1;
    end
    checks++;
    if (cnt !== 1) begin
      errors++; $display("FAIL level_reedge: got %0d commits expected 1", cnt);
    end
    bus.LD_Row = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 3'(a % 8);
    push_expected(7);
    for (int k = 0; k < 10; k++) last_row[k] = exp_q.pop_front();
    @(negedge Clk);
  endtask

  task automatic test_reset_mid();
    int cnt;
    logic [15:0] e;
    for (int a = 0; a < 256; a++) mem[a] = 3'($urandom_range(1, 7));
    @(negedge Clk);
    bus.LD_Row = 1'b1;
    bus.rowNum = 8'd5;
    @(posedge Clk);
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge Clk);
      if (bus.rowReady) cnt++;
      if (j == 2) bus.LD_Row = 1'b0;
      if (j == 5) reset = 1'b1;
      if (j == 6) begin
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.ram_addr !== 8'd0) begin
          errors++; $display("FAIL midreset_outputs: busy=%b ram_addr=%0d expected 0 0", bus.busy, bus.ram_addr);
        end
        for (int k = 0; k < 10; k++) begin
          checks++;
          if (bus.Row[k] !== 16'h0000) begin
            errors++; $display("FAIL midreset_row[%0d]: got %h expected 0000", k, bus.Row[k]);
          end
          last_row[k] = 16'h0000;
        end
      end
    end
    checks++;
    if (cnt !== 0) begin
      errors++; $display("FAIL midreset_ready: got %0d pulses expected 0", cnt);
    end
    push_expected(0);
    drive_fetch(8'd0);
    checks++;
    if (obs_ready[12] !== 1'b1) begin
      errors++; $display("FAIL midreset_refetch_ready: got %b expected 1", obs_ready[12]);
    end
    for (int k = 0; k < 10; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_row[k] !== e) begin
        errors++; $display("FAIL midreset_refetch_row[%0d]: got %h expected %h", k, obs_row[k], e);
      end
      last_row[k] = e;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    for (int n = 0; n < 3; n++) begin
      int r;
      r = $urandom_range(0, 19);
      push_expected(r);
      drive_fetch(8'(r));
      for (int k = 0; k < 10; k++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_row[k] !== e || obs_pre[k] !== last_row[k]) begin
          errors++;
          $display("FAIL b2b%0d_row[%0d]: got %h/%h expected %h/%h", n, k, obs_pre[k], obs_row[k], last_row[k], e);
        end
        last_row[k] = e;
      end
    end
  endtask

  initial begin
    pal_tab[0] = 16'h0000; pal_tab[1] = 16'h00FF; pal_tab[2] = 16'h00F0; pal_tab[3] = 16'h0F00;
    pal_tab[4] = 16'h0FF0; pal_tab[5] = 16'h0F0F; pal_tab[6] = 16'h0F80; pal_tab[7] = 16'h000F;
    for (int a = 0; a < 256; a++) mem[a] = 3'd0;
    reset      = 1'b1;
    bus.LD_Row = 1'b0;
    bus.rowNum = 8'd0;
    clear_piece();

    test_reset();
    test_normal();
    test_overlay();
    test_blank();
    test_random();
    test_level();
    test_reset_mid();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
